divide_seq: RTL and testbench

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/divide_seq.sv | 135 +++++++++++++
 tb/tb_divide_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// Sequential restoring divider: one quotient bit per cycle.
// N-bit dividend/quotient, M-bit divisor/remainder, done pulse on completion.
module divide_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // dvd_q shifts the dividend out of its MSB while quotient bits
    // enter at its LSB, so after N steps it holds the quotient.
    logic [N-1:0]  dvd_q;
    logic [M-1:0]  dsr_q;
    logic [M-1:0]  prem_q;
    logic [CW-1:0] cnt_q;

    logic [M:0]    r_shift;
    logic [M:0]    r_diff;
    logic          fits;

    // One restoring step. The kept remainder is always below the
    // divisor, so r_shift < 2*divisor: the borrow bit of the M+1-bit
    // difference is exactly "r_shift < divisor", and a successful
    // difference always fits back into M bits.
    always_comb begin
        r_shift = {prem_q, dvd_q[N-1]};
        r_diff  = r_shift - {1'b0, dsr_q};
        fits    = ~r_diff[M];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q  <= dividend;
                        dsr_q  <= divisor;
                        prem_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    dvd_q  <= {dvd_q[N-2:0], fits};
                    prem_q <= fits ? r_diff[M-1:0] : r_shift[M-1:0];
                    cnt_q  <= cnt_q + CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    if (dsr_q == '0) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= dvd_q;
                        remainder   <= prem_q;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_seq.sv
// Self-checking bench for divide_seq: directed cases plus a full
// operand sweep against a plain-arithmetic reference model.
module tb_divide_seq;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    divide_seq #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned integer division, divide-by-zero convention.
    task automatic model(input int a, input int b, output int q,
                         output int r, output int z);
        if (b == 0) begin
            q = (1 << N) - 1;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, scramble inputs and poke start
    // while busy, then check latency, results and the single pulse.
    task automatic run_op(input int a, input int b, input string tag);
        int q, r, z, lat, k;
        model(a, b, q, r, z);
        lat = (b == 0) ? 1 : N + 1;
        dividend = N'(a);
        divisor  = M'(b);
        start    = 1'b1;
        tick();
        dividend = N'($urandom);
        divisor  = M'($urandom);
        start    = ($urandom_range(0, 3) == 0);
        chk({tag, ".busy0"}, busy, 1);
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
            dividend = N'($urandom);
            divisor  = M'($urandom);
            start    = !done && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        chk({tag, ".lat"}, k, lat);
        chk({tag, ".q"}, quotient, q);
        chk({tag, ".r"}, remainder, r);
        chk({tag, ".dz"}, div_by_zero, z);
        tick();
        chk({tag, ".pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".hold"}, quotient, q);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2, q, r, z;
        bit saw;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.done", done, 0);
        chk("rst.busy", busy, 0);
        chk("rst.dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(100, 7, "d100_7");
        run_op(255, 15, "d255_15");
        run_op(5, 9, "d5_9");
        run_op(37, 0, "d37_0");
        run_op(40, 8, "d40_8");

        // Start pulsed mid-operation with new operands is ignored.
        dividend = 200;
        divisor  = 3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("ign.busy0", busy, 1);
        for (int e = 1; e <= 10; e++) begin
            start = (e == 4);
            if (e == 4) begin
                dividend = 9;
                divisor  = 2;
            end
            tick();
            chk("ign.busy", busy, (e <= 9) ? 1 : 0);
            chk("ign.done", done, (e == 9) ? 1 : 0);
        end
        start = 1'b0;
        chk("ign.q", quotient, 66);
        chk("ign.r", remainder, 2);

        // Start held high restarts on the first edge back in IDLE.
        dividend = 40;
        divisor  = 8;
        start    = 1'b1;
        tick();
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        chk("held.lat1", k, N + 1);
        k2 = 0;
        do begin
            tick();
            k2++;
        end while (!done && k2 < 30);
        start = 1'b0;
        chk("held.gap", k2, N + 3);
        chk("held.q", quotient, 5);
        chk("held.r", remainder, 0);
        tick();
        tick();
        chk("held.idle", busy, 0);

        // Asynchronous reset abandons an operation in flight.
        dividend = 100;
        divisor  = 7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst.q", quotient, 0);
        chk("arst.r", remainder, 0);
        chk("arst.done", done, 0);
        chk("arst.busy", busy, 0);
        chk("arst.dz", div_by_zero, 0);
        tick();
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (done) saw = 1'b1;
        end
        chk("arst.nodone", saw, 0);
        run_op(100, 7, "after_rst");

        // Exhaustive operand sweep, with scrambled inputs while busy.
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << M); b++) begin
                run_op(a, b, "sweep");
            end
        end

        // Random operations with random idle gaps.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_op($urandom_range(0, (1 << N) - 1),
                   $urandom_range(0, (1 << M) - 1), "rand");
        end

        model(255, 0, q, r, z);
        run_op(255, 0, "dz_last");
        chk("dz_last.ones", quotient, q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
